// File: rtl/decode_stage.sv
// RV32I decode stage: registered execute-stage controls behind a
// valid/ready handshake on both sides, with an optional one-bubble load-use interlock.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  drop the held and the incoming instruction
//   in_valid_i/in_ready_o    fetch-side handshake, instr_i instruction word
//   out_valid_o/out_ready_i  execute-side handshake
//   reg_raddr_a_o/b_o,
//   reg_waddr_o              rs1, rs2, rd (zero-extended to ADDR_WIDTH)
//   alu_op_o, imm_sel_o, data_a_mux_o, data_b_mux_o, pc_mux_o,
//   branch_mux_o, jal_op_o, reg_we_o, mem_read_o, mem_write_o,
//   illegal_o                decoded controls
//
// Build option:
//   DECODE_STAGE_LOAD_USE_INTERLOCK_EN
//     defined:   stall a consumer of a held load's rd for one bubble.
//     undefined: no interlock; execute handles forwarding/stall.
module decode_stage #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] reg_raddr_a_o,
    output logic [ADDR_WIDTH-1:0] reg_raddr_b_o,
    output logic [ADDR_WIDTH-1:0] reg_waddr_o,
    output logic [3:0]            alu_op_o,
    output logic [2:0]            imm_sel_o,
    output logic                  data_a_mux_o,
    output logic                  data_b_mux_o,
    output logic [1:0]            pc_mux_o,
    output logic [2:0]            branch_mux_o,
    output logic                  jal_op_o,
    output logic                  reg_we_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_MISC   = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] ra;
        logic [ADDR_WIDTH-1:0] rb;
        logic [ADDR_WIDTH-1:0] rw;
        logic [3:0]            alu;
        logic [2:0]            imm;
        logic                  am;
        logic                  bm;
        logic [1:0]            pc;
        logic [2:0]            br;
        logic                  jal;
        logic                  we;
        logic                  mr;
        logic                  mw;
        logic                  ill;
    } dec_t;

    dec_t       dec, dec_d, dec_q;
    logic       valid_d, valid_q;
    logic       hazard, accept, ill;
    logic [6:0] opcode, f7;
    logic [2:0] f3;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    function automatic logic [3:0] alu_of(input logic [2:0] fn, input logic alt);
        logic [3:0] r;
        case (fn)
            3'd0:    r = alt ? 4'd1 : 4'd0;
            3'd1:    r = 4'd2;
            3'd2:    r = 4'd3;
            3'd3:    r = 4'd4;
            3'd4:    r = 4'd5;
            3'd5:    r = alt ? 4'd7 : 4'd6;
            3'd6:    r = 4'd8;
            default: r = 4'd9;
        endcase
        return r;
    endfunction

    always_comb begin
        dec    = '0;
        ill    = 1'b0;
        dec.ra = ADDR_WIDTH'(instr_i[19:15]);
        dec.rb = ADDR_WIDTH'(instr_i[24:20]);
        dec.rw = ADDR_WIDTH'(instr_i[11:7]);
        unique case (opcode)
            OPC_LUI: begin
                dec.imm = 3'd3; dec.bm = 1'b1; dec.alu = 4'd10; dec.we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm = 3'd3; dec.am = 1'b1; dec.bm = 1'b1; dec.we = 1'b1;
            end
            OPC_JAL: begin
                dec.imm = 3'd4; dec.pc = 2'd2; dec.jal = 1'b1;
                dec.am  = 1'b1; dec.bm = 1'b1; dec.we  = 1'b1;
            end
            OPC_JALR: begin
                dec.imm = 3'd0; dec.pc = 2'd3; dec.jal = 1'b1;
                dec.bm  = 1'b1; dec.we = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm = 3'd2; dec.pc = 2'd1;
                case (f3)
                    3'd0:    dec.br = 3'd1;
                    3'd1:    dec.br = 3'd2;
                    3'd4:    dec.br = 3'd3;
                    3'd5:    dec.br = 3'd4;
                    3'd6:    dec.br = 3'd5;
                    3'd7:    dec.br = 3'd6;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.imm = 3'd0; dec.bm = 1'b1; dec.mr = 1'b1; dec.we = 1'b1;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                dec.imm = 3'd1; dec.bm = 1'b1; dec.mw = 1'b1;
                ill = f3[2] || (f3 == 3'd3);
            end
            OPC_OPIMM: begin
                dec.imm = 3'd0; dec.bm = 1'b1; dec.we = 1'b1;
                // only the shift-right immediate carries an alternate op
                dec.alu = alu_of(f3, (f3 == 3'd5) && f7[5]);
                ill = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                      ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OPC_OP: begin
                dec.we  = 1'b1;
                dec.alu = alu_of(f3, f7[5]);
                ill = !((f7 == 7'h00) ||
                        ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_MISC, OPC_SYSTEM: ;
            default: ill = 1'b1;
        endcase
        if (dec.rw == '0) dec.we = 1'b0;
        // an illegal instruction keeps only its register fields
        if (ill) begin
            dec.alu = '0; dec.imm = '0; dec.am = 1'b0; dec.bm = 1'b0;
            dec.pc  = '0; dec.br  = '0; dec.jal = 1'b0; dec.we = 1'b0;
            dec.mr  = 1'b0; dec.mw = 1'b0;
        end
        dec.ill = ill;
    end

`ifdef DECODE_STAGE_LOAD_USE_INTERLOCK_EN
    logic rs1_used, rs2_used;

    always_comb begin
        rs1_used = (opcode == OPC_JALR)  || (opcode == OPC_BRANCH) ||
                   (opcode == OPC_LOAD)  || (opcode == OPC_STORE)  ||
                   (opcode == OPC_OPIMM) || (opcode == OPC_OP);
        rs2_used = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) ||
                   (opcode == OPC_OP);
        hazard = valid_q && dec_q.mr && (dec_q.rw != '0) &&
                 ((rs1_used && (dec.ra == dec_q.rw)) ||
                  (rs2_used && (dec.rb == dec_q.rw)));
    end
`else
    assign hazard = 1'b0;
`endif

    assign in_ready_o = rst_ni && (!valid_q || out_ready_i) && !hazard;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign reg_raddr_a_o = dec_q.ra;
    assign reg_raddr_b_o = dec_q.rb;
    assign reg_waddr_o   = dec_q.rw;
    assign alu_op_o      = dec_q.alu;
    assign imm_sel_o     = dec_q.imm;
    assign data_a_mux_o  = dec_q.am;
    assign data_b_mux_o  = dec_q.bm;
    assign pc_mux_o      = dec_q.pc;
    assign branch_mux_o  = dec_q.br;
    assign jal_op_o      = dec_q.jal;
    assign reg_we_o      = dec_q.we;
    assign mem_read_o    = dec_q.mr;
    assign mem_write_o   = dec_q.mw;
    assign illegal_o     = dec_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: randomized and directed instructions,
// expected decode queued at issue and compared by a separate monitor.
module tb_decode_stage;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   instr = 32'h0;
    logic          in_ready_o, out_valid_o;
    logic [AW-1:0] reg_raddr_a_o, reg_raddr_b_o, reg_waddr_o;
    logic [3:0]    alu_op_o;
    logic [2:0]    imm_sel_o, branch_mux_o;
    logic          data_a_mux_o, data_b_mux_o;
    logic [1:0]    pc_mux_o;
    logic          jal_op_o, reg_we_o, mem_read_o, mem_write_o, illegal_o;

    decode_stage #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o), .instr_i(instr),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .reg_raddr_a_o(reg_raddr_a_o), .reg_raddr_b_o(reg_raddr_b_o),
        .reg_waddr_o(reg_waddr_o), .alu_op_o(alu_op_o), .imm_sel_o(imm_sel_o),
        .data_a_mux_o(data_a_mux_o), .data_b_mux_o(data_b_mux_o),
        .pc_mux_o(pc_mux_o), .branch_mux_o(branch_mux_o), .jal_op_o(jal_op_o),
        .reg_we_o(reg_we_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] ra, rb, rw;
        logic [3:0]    alu;
        logic [2:0]    imm;
        logic          am, bm;
        logic [1:0]    pc;
        logic [2:0]    br;
        logic          jal, we, mr, mw, ill;
    } dec_t;

    dec_t act;
    assign act = {reg_raddr_a_o, reg_raddr_b_o, reg_waddr_o, alu_op_o,
                  imm_sel_o, data_a_mux_o, data_b_mux_o, pc_mux_o,
                  branch_mux_o, jal_op_o, reg_we_o, mem_read_o,
                  mem_write_o, illegal_o};

    dec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // ALU op for register/immediate arithmetic: ADD SLL SLT SLTU XOR SRL OR AND,
    // with SUB/SRA as the alternate forms of funct3 0/5.
    function automatic logic [3:0] alu_ref(input logic [2:0] fn, input bit alt);
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (alt && fn == 3'd0) return 4'd1;
        if (alt && fn == 3'd5) return 4'd7;
        return tab[fn];
    endfunction

    function automatic dec_t model(input logic [31:0] w);
        dec_t       e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit         ok, wr;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        e = '0; ok = 1; wr = 0;
        e.ra = w[19:15]; e.rb = w[24:20]; e.rw = w[11:7];
        case (op)
            7'h37: begin e.imm = 3; e.bm = 1; e.alu = 10; wr = 1; end
            7'h17: begin e.imm = 3; e.am = 1; e.bm = 1; wr = 1; end
            7'h6F: begin e.imm = 4; e.pc = 2; e.jal = 1; e.am = 1; e.bm = 1; wr = 1; end
            7'h67: begin e.imm = 0; e.pc = 3; e.jal = 1; e.bm = 1; wr = 1; end
            7'h63: begin
                e.imm = 2; e.pc = 1;
                if (f3 == 0) e.br = 1;
                else if (f3 == 1) e.br = 2;
                else if (f3 >= 4) e.br = 3'(f3 - 1);
                else ok = 0;
            end
            7'h03: begin
                e.bm = 1; e.mr = 1; wr = 1;
                ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
            end
            7'h23: begin e.imm = 1; e.bm = 1; e.mw = 1; ok = (f3 <= 2); end
            7'h13: begin
                e.bm = 1; wr = 1;
                e.alu = alu_ref(f3, (f3 == 5) && f7[5]);
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
            end
            7'h33: begin
                wr = 1;
                e.alu = alu_ref(f3, f7[5]);
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            7'h0F, 7'h73: ;
            default: ok = 0;
        endcase
        e.we = wr && (e.rw != 0);
        if (!ok) begin
            e = '0;
            e.ra = w[19:15]; e.rb = w[24:20]; e.rw = w[11:7];
            e.ill = 1;
        end
        return e;
    endfunction

    function automatic bit hz_ref(input logic [31:0] w);
`ifdef DECODE_STAGE_LOAD_USE_INTERLOCK_EN
        logic [6:0] op;
        bit r1, r2;
        op = w[6:0];
        r1 = (op == 7'h67) || (op == 7'h63) || (op == 7'h03) ||
             (op == 7'h23) || (op == 7'h13) || (op == 7'h33);
        r2 = (op == 7'h63) || (op == 7'h23) || (op == 7'h33);
        if (exp_q.size() == 0) return 0;
        if (!exp_q[0].mr || exp_q[0].rw == 0) return 0;
        return (r1 && w[19:15] == exp_q[0].rw) || (r2 && w[24:20] == exp_q[0].rw);
`else
        return (w == 32'h0) && 1'b0;
`endif
    endfunction

    // monitor: checks ready and outputs before each edge, valid after it
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", 64'(in_ready_o),
                    64'((exp_q.size() == 0 || out_ready) && !hz_ref(instr)));
                if (out_valid_o) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_out: got valid expected empty (cycle %0d)", cyc);
                    end else begin
                        chk("outputs", 64'(act), 64'(exp_q[0]));
                        if (out_ready || flush) void'(exp_q.pop_front());
                    end
                end
            end
            @(posedge clk);
            #2;
            if (rst_n) chk("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
        end
    end

    // called at posedge+1; returns at the next posedge+1
    task automatic step(input bit v, input logic [31:0] w, input bit rdy,
                        input bit fl, output bit acc);
        in_valid = v; instr = w; out_ready = rdy; flush = fl;
        @(negedge clk);
        #1;
        acc = v && in_ready_o && !fl;
        if (acc) exp_q.push_back(model(w));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [31:0] w, input bit rdy, output int at);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 20) begin
            step(1, w, rdy, 0, acc);
            n++;
        end
        at = cyc;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: got no accept expected accept for %h", w);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 32'h0, 1, 0, acc);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op, f7;
        int k = $urandom_range(0, 12);
        case (k)
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
            8: op = 7'h33;  9: op = 7'h0F; 10: op = 7'h73;
            11: op = 7'($urandom);
            default: return $urandom;
        endcase
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), op};
    endfunction

    initial begin
        int a, b;
        bit acc;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(act), 64'(0));
        chk("reset_valid", 64'(out_valid_o), 64'(0));
        chk("reset_in_ready", 64'(in_ready_o), 64'(0));
        rst_n = 1'b1;
        idle(2);

        // branch decode
        issue(32'h00208063, 0, a);
        chk("beq_branch_mux", 64'(branch_mux_o), 64'(1));
        chk("beq_pc_mux", 64'(pc_mux_o), 64'(1));
        chk("beq_imm_sel", 64'(imm_sel_o), 64'(2));
        chk("beq_reg_we", 64'(reg_we_o), 64'(0));
        idle(1);
        issue(32'h0020C063, 0, a);
        chk("blt_branch_mux", 64'(branch_mux_o), 64'(3));
        idle(1);

        // JALR
        issue(32'h000100E7, 0, a);
        chk("jalr_pc_mux", 64'(pc_mux_o), 64'(3));
        chk("jalr_jal_op", 64'(jal_op_o), 64'(1));
        chk("jalr_waddr", 64'(reg_waddr_o), 64'(1));
        chk("jalr_rs1", 64'(reg_raddr_a_o), 64'(2));
        chk("jalr_reg_we", 64'(reg_we_o), 64'(1));
        idle(1);

        // illegal all-zero word
        issue(32'h00000000, 0, a);
        chk("ill_flag", 64'(illegal_o), 64'(1));
        chk("ill_reg_we", 64'(reg_we_o), 64'(0));
        chk("ill_mem_read", 64'(mem_read_o), 64'(0));
        chk("ill_mem_write", 64'(mem_write_o), 64'(0));
        idle(1);

        // load-use
        issue(32'h0000A283, 1, a);
        issue(32'h00728333, 1, b);
`ifdef DECODE_STAGE_LOAD_USE_INTERLOCK_EN
        chk("load_use_bubbles", 64'(b - a - 1), 64'(1));
`else
        chk("load_use_bubbles", 64'(b - a - 1), 64'(0));
`endif
        idle(2);

        // backpressure then full-rate resume
        issue(32'h003160B3, 0, a);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00A00593, 0, 0, acc);
            chk("bp_stall_accept", 64'(acc), 64'(0));
        end
        issue(32'h00A00593, 1, a);
        issue(32'h40B50633, 1, b);
        chk("bp_resume_rate", 64'(b - a), 64'(1));
        issue(32'h00C586B3, 1, b);
        idle(2);

        // flush during a simultaneous in/out transfer
        issue(32'h00100093, 0, a);
        step(1, 32'h00200113, 1, 1, acc);
        chk("flush_valid", 64'(out_valid_o), 64'(0));
        idle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, acc);
        end
        idle(3);

        // async reset mid-stream
        issue(32'h00832383, 0, a);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("areset_outputs", 64'(act), 64'(0));
        chk("areset_valid", 64'(out_valid_o), 64'(0));
        chk("areset_in_ready", 64'(in_ready_o), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        issue(32'h00528293, 1, a);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
